instr_mem_mp: RTL and testbench

- Multi-core instruction memory for the matrix-multiply processor array.
- Holds one shared program and serves N_CORES independent fetch ports through a single internal read port.
- Arbitration is round-robin; identical same-cycle addresses can optionally be coalesced.
- Replaces the fixed initial-block ROM with a streamed program-load port and a load/ready state machine.

---
 rtl/isa_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/instr_mem_mp.sv | 181 ++++++++++++++++++
 tb/tb_instr_mem_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - instruction set constants and memory state type for the matrix-multiply array
package isa_pkg;

  localparam int INSTR_W = 17;
  localparam int OPC_W   = 5;
  localparam int OPND_W  = INSTR_W - OPC_W;

  localparam logic [OPC_W-1:0] OPC_LDAC  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_LDIAC = 5'd5;
  localparam logic [OPC_W-1:0] OPC_STAC  = 5'd8;
  localparam logic [OPC_W-1:0] OPC_MVAC  = 5'd9;
  localparam logic [OPC_W-1:0] OPC_JPNZ  = 5'd24;
  localparam logic [OPC_W-1:0] OPC_NOP   = 5'd28;
  localparam logic [OPC_W-1:0] OPC_CLAC  = 5'd30;
  localparam logic [OPC_W-1:0] OPC_ENDOP = 5'd31;

  // Returned for fetches that fall outside the populated RAM
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OPC_NOP, {OPND_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } mem_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin grant with externally steered rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, wrapping around
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(j);
        grant[j]  = 1'b1;
      end
    end
  end

  // Pointer moves one past the last served port; the caller decides which that is
  always_comb begin
    int nxt;
    nxt   = 0;
    ptr_d = ptr_q;
    if (adv) begin
      nxt = int'(adv_idx) + 1;
      if (nxt >= N) nxt = 0;
      ptr_d = IW'(nxt);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/instr_mem_mp.sv
// rtl/instr_mem_mp.sv - shared instruction RAM with streamed load and N round-robin fetch ports (INSTR_MEM_COALESCE_EN)
module instr_mem_mp #(
  parameter int INSTR_W = isa_pkg::INSTR_W,
  parameter int OPC_W   = isa_pkg::OPC_W,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 2048,
  parameter int N_CORES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_start,
  input  logic                       prog_valid,
  input  logic [INSTR_W-1:0]         prog_data,
  input  logic                       prog_last,
  output logic                       prog_ready,
  output logic                       mem_ready,
  output logic                       load_err,
  input  logic [N_CORES-1:0]         fetch_req,
  input  logic [N_CORES*ADDR_W-1:0]  fetch_addr,
  output logic [N_CORES-1:0]         fetch_valid,
  output logic [N_CORES*INSTR_W-1:0] fetch_instr,
  output logic [N_CORES-1:0]         addr_err
);
  import isa_pkg::*;

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [ADDR_W:0]    DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [INSTR_W-1:0] NOP_W    = INSTR_W'(NOP_INSTR);

  mem_state_e state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              load_err_q, load_err_d;
  logic              wr_en;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] ram_rdata_q;
  logic               oor_q, oor_d;

  logic [N_CORES-1:0] fetch_valid_q, fetch_valid_d;
  logic [N_CORES-1:0] addr_err_q, addr_err_d;
  logic [N_CORES-1:0][INSTR_W-1:0] hold_q, hold_d;

  logic               grant_en;
  logic [N_CORES-1:0] arb_req, grant, served;
  logic [IW-1:0]      grant_idx, served_hi;
  logic               grant_vld;
  logic [ADDR_W-1:0]  gaddr;
  logic [INSTR_W-1:0] rd_word;

  // Load/ready sequencing; prog_start always restarts at word 0
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    load_err_d = load_err_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (prog_start) begin
          state_d    = ST_LOAD;
          wptr_d     = '0;
          load_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (prog_start) begin
          wptr_d = '0;
        end else if (prog_valid) begin
          wr_en = 1'b1;
          if (prog_last) begin
            state_d = ST_READY;
          end else if (wptr_q == LAST_PTR) begin
            state_d    = ST_READY;
            load_err_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      ST_READY: begin
        if (prog_start) begin
          state_d    = ST_LOAD;
          wptr_d     = '0;
          load_err_d = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Program RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[MW-1:0]] <= prog_data;
  end

  // Cores already holding a pending valid sit out this cycle's arbitration
  assign grant_en = (state_q == ST_READY) && !prog_start;
  assign arb_req  = grant_en ? (fetch_req & ~fetch_valid_q) : '0;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .adv       (grant_vld),
    .adv_idx   (served_hi),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Address of the granted core drives the single read port
  always_comb begin
    gaddr = '0;
    for (int c = 0; c < N_CORES; c++) begin
      if (grant[c]) gaddr = fetch_addr[c*ADDR_W +: ADDR_W];
    end
  end

  // Cores answered by this read; with coalescing, every requester on the same address
  always_comb begin
    served    = grant;
    served_hi = grant_idx;
`ifdef INSTR_MEM_COALESCE_EN
    for (int c = 0; c < N_CORES; c++) begin
      if (grant_vld && arb_req[c] && (fetch_addr[c*ADDR_W +: ADDR_W] == gaddr)) begin
        served[c] = 1'b1;
        served_hi = IW'(c);
      end
    end
`endif
  end

  assign oor_d         = grant_vld && ({1'b0, gaddr} >= DEPTH_W);
  assign fetch_valid_d = served;
  assign addr_err_d    = oor_d ? served : '0;

  // Registered RAM read; out-of-range index is harmless since the NOP substitute wins
  always_ff @(posedge clk) begin
    if (grant_vld) ram_rdata_q <= mem[gaddr[MW-1:0]];
  end

  assign rd_word = oor_q ? NOP_W : ram_rdata_q;

  // Each core keeps its last delivered instruction until its next valid
  always_comb begin
    hold_d = hold_q;
    for (int c = 0; c < N_CORES; c++) begin
      if (fetch_valid_q[c]) hold_d[c] = rd_word;
    end
  end

  // State, pointer and fetch-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      wptr_q        <= '0;
      load_err_q    <= 1'b0;
      oor_q         <= 1'b0;
      fetch_valid_q <= '0;
      addr_err_q    <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_err_q    <= load_err_d;
      oor_q         <= oor_d;
      fetch_valid_q <= fetch_valid_d;
      addr_err_q    <= addr_err_d;
      hold_q        <= hold_d;
    end
  end

  assign prog_ready  = (state_q == ST_LOAD);
  assign mem_ready   = (state_q == ST_READY);
  assign load_err    = load_err_q;
  assign fetch_valid = fetch_valid_q;
  assign addr_err    = addr_err_q;
  assign fetch_instr = hold_d;

endmodule

// File: tb/tb_instr_mem_mp.sv
// tb/tb_instr_mem_mp.sv - directed self-checking bench for instr_mem_mp
module tb_instr_mem_mp;

  localparam int IW = 17;
  localparam int AW = 12;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic prog_start, prog_valid, prog_last, prog_ready, mem_ready, load_err;
  logic [IW-1:0] prog_data;
  logic [NC-1:0] fetch_req, fetch_valid, addr_err;
  logic [NC*AW-1:0] fetch_addr;
  logic [NC*IW-1:0] fetch_instr;

  logic s_start, s_valid, s_last, s_prog_ready, s_mem_ready, s_load_err;
  logic [IW-1:0] s_data;
  logic [NC-1:0] s_req, s_fvalid, s_addr_err;
  logic [NC*AW-1:0] s_addr;
  logic [NC*IW-1:0] s_instr;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [IW-1:0] prog_a [4] = '{17'h0A000, 17'h16000, 17'h1C000, 17'h1F000};
  logic [IW-1:0] prog_b [4] = '{17'h03001, 17'h05002, 17'h08003, 17'h1E004};

  instr_mem_mp dut (
    .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .mem_ready(mem_ready), .load_err(load_err), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .addr_err(addr_err)
  );

  instr_mem_mp #(.DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .prog_start(s_start), .prog_valid(s_valid),
    .prog_data(s_data), .prog_last(s_last), .prog_ready(s_prog_ready),
    .mem_ready(s_mem_ready), .load_err(s_load_err), .fetch_req(s_req),
    .fetch_addr(s_addr), .fetch_valid(s_fvalid), .fetch_instr(s_instr),
    .addr_err(s_addr_err)
  );

  function automatic logic [IW-1:0] instr_of(input int c);
    return fetch_instr[c*IW +: IW];
  endfunction

  function automatic logic [IW-1:0] s_instr_of(input int c);
    return s_instr[c*IW +: IW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [AW-1:0] a0, a1, a2, a3);
    fetch_addr = {a3, a2, a1, a0};
  endtask

  task automatic load_prog(input logic [IW-1:0] w0, w1, w2, w3);
    logic [IW-1:0] w [4];
    w = '{w0, w1, w2, w3};
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prog_valid = 1'b1;
      prog_data  = w[i];
      prog_last  = (i == 3);
      tick();
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    if (prog_ready !== 1'b0) begin $display("FAIL rst_prog_ready: got %b want 0", prog_ready); err_cnt++; end vec_cnt++;
    if (mem_ready !== 1'b0) begin $display("FAIL rst_mem_ready: got %b want 0", mem_ready); err_cnt++; end vec_cnt++;
    if (load_err !== 1'b0) begin $display("FAIL rst_load_err: got %b want 0", load_err); err_cnt++; end vec_cnt++;
    if (fetch_valid !== 4'b0) begin $display("FAIL rst_fetch_valid: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
    if (fetch_instr !== '0) begin $display("FAIL rst_fetch_instr: got %h want 0", fetch_instr); err_cnt++; end vec_cnt++;
    if (addr_err !== 4'b0) begin $display("FAIL rst_addr_err: got %b want 0000", addr_err); err_cnt++; end vec_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    if (prog_ready !== 1'b1) begin $display("FAIL load_prog_ready: got %b want 1", prog_ready); err_cnt++; end vec_cnt++;
    for (int i = 0; i < 4; i++) begin
      prog_valid = 1'b1;
      prog_data  = prog_a[i];
      prog_last  = (i == 3);
      tick();
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    if (mem_ready !== 1'b1) begin $display("FAIL load_mem_ready: got %b want 1", mem_ready); err_cnt++; end vec_cnt++;
    if (prog_ready !== 1'b0) begin $display("FAIL load_prog_ready_done: got %b want 0", prog_ready); err_cnt++; end vec_cnt++;
    set_addrs(12'd3, 12'd0, 12'd0, 12'd0);
    fetch_req = 4'b0001;
    tick();
    fetch_req = 4'b0000;
    if (fetch_valid !== 4'b0001) begin $display("FAIL load_fetch_valid: got %b want 0001", fetch_valid); err_cnt++; end vec_cnt++;
    if (instr_of(0) !== 17'h1F000) begin $display("FAIL load_fetch_instr: got %h want 1f000", instr_of(0)); err_cnt++; end vec_cnt++;
    tick();
    if (fetch_valid !== 4'b0000) begin $display("FAIL load_valid_pulse: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
    if (instr_of(0) !== 17'h1F000) begin $display("FAIL load_instr_hold: got %h want 1f000", instr_of(0)); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_v;
    int ec;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    load_prog(prog_a[0], prog_a[1], prog_a[2], prog_a[3]);
    set_addrs(12'd0, 12'd1, 12'd2, 12'd3);
    fetch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      ec    = k % 4;
      exp_v = 4'b0001 << ec;
      if (fetch_valid !== exp_v) begin $display("FAIL rr_valid[%0d]: got %b want %b", k, fetch_valid, exp_v); err_cnt++; end vec_cnt++;
      if (instr_of(ec) !== prog_a[ec]) begin $display("FAIL rr_instr[%0d]: got %h want %h", k, instr_of(ec), prog_a[ec]); err_cnt++; end vec_cnt++;
    end
    fetch_req = 4'b0000;
    tick();
    if (fetch_valid !== 4'b0000) begin $display("FAIL rr_idle: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_coalesce();
    set_addrs(12'd1, 12'd1, 12'd1, 12'd1);
    fetch_req = 4'b1111;
`ifdef INSTR_MEM_COALESCE_EN
    tick();
    fetch_req = 4'b0000;
    if (fetch_valid !== 4'b1111) begin $display("FAIL coal_valid: got %b want 1111", fetch_valid); err_cnt++; end vec_cnt++;
    for (int c = 0; c < NC; c++) begin
      if (instr_of(c) !== 17'h16000) begin $display("FAIL coal_instr[%0d]: got %h want 16000", c, instr_of(c)); err_cnt++; end vec_cnt++;
    end
`else
    for (int k = 0; k < 4; k++) begin
      int ec;
      logic [NC-1:0] exp_v;
      tick();
      ec    = (k + 1) % 4;
      exp_v = 4'b0001 << ec;
      if (fetch_valid !== exp_v) begin $display("FAIL coal_seq_valid[%0d]: got %b want %b", k, fetch_valid, exp_v); err_cnt++; end vec_cnt++;
      if (instr_of(ec) !== 17'h16000) begin $display("FAIL coal_seq_instr[%0d]: got %h want 16000", k, instr_of(ec)); err_cnt++; end vec_cnt++;
    end
    fetch_req = 4'b0000;
`endif
    tick();
    if (fetch_valid !== 4'b0000) begin $display("FAIL coal_idle: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_overflow();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 17'h00100 + 17'(i);
      tick();
      if (i == 6) begin
        if (s_prog_ready !== 1'b1) begin $display("FAIL ovf_still_loading: got %b want 1", s_prog_ready); err_cnt++; end vec_cnt++;
      end
    end
    s_valid = 1'b0;
    if (s_mem_ready !== 1'b1) begin $display("FAIL ovf_mem_ready: got %b want 1", s_mem_ready); err_cnt++; end vec_cnt++;
    if (s_load_err !== 1'b1) begin $display("FAIL ovf_load_err: got %b want 1", s_load_err); err_cnt++; end vec_cnt++;
    s_addr = {12'd0, 12'd0, 12'd9, 12'd7};
    s_req  = 4'b0011;
    tick();
    s_req = 4'b0010;
    if (s_fvalid !== 4'b0001) begin $display("FAIL ovf_last_valid: got %b want 0001", s_fvalid); err_cnt++; end vec_cnt++;
    if (s_instr_of(0) !== 17'h00107) begin $display("FAIL ovf_last_word: got %h want 00107", s_instr_of(0)); err_cnt++; end vec_cnt++;
    if (s_addr_err !== 4'b0000) begin $display("FAIL ovf_last_addr_err: got %b want 0000", s_addr_err); err_cnt++; end vec_cnt++;
    tick();
    s_req = 4'b0000;
    if (s_fvalid !== 4'b0010) begin $display("FAIL ovf_oor_valid: got %b want 0010", s_fvalid); err_cnt++; end vec_cnt++;
    if (s_instr_of(1) !== 17'h1C000) begin $display("FAIL ovf_oor_nop: got %h want 1c000", s_instr_of(1)); err_cnt++; end vec_cnt++;
    if (s_addr_err !== 4'b0010) begin $display("FAIL ovf_oor_addr_err: got %b want 0010", s_addr_err); err_cnt++; end vec_cnt++;
    tick();
    if (s_addr_err !== 4'b0000) begin $display("FAIL ovf_addr_err_pulse: got %b want 0000", s_addr_err); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_reset_mid_load();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1;
      prog_data  = 17'h00111 * 17'(i + 1);
      tick();
    end
    prog_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if (mem_ready !== 1'b0) begin $display("FAIL rml_mem_ready: got %b want 0", mem_ready); err_cnt++; end vec_cnt++;
    if (prog_ready !== 1'b0) begin $display("FAIL rml_prog_ready: got %b want 0", prog_ready); err_cnt++; end vec_cnt++;
    set_addrs(12'd0, 12'd1, 12'd2, 12'd3);
    fetch_req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (fetch_valid !== 4'b0000) begin $display("FAIL rml_no_valid[%0d]: got %b want 0000", k, fetch_valid); err_cnt++; end vec_cnt++;
    end
    load_prog(prog_b[0], prog_b[1], prog_b[2], prog_b[3]);
    if (fetch_valid !== 4'b0000) begin $display("FAIL rml_no_valid_load: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
    tick();
    fetch_req = 4'b0000;
    if (fetch_valid !== 4'b0001) begin $display("FAIL rml_valid_after: got %b want 0001", fetch_valid); err_cnt++; end vec_cnt++;
    if (instr_of(0) !== 17'h03001) begin $display("FAIL rml_instr_after: got %h want 03001", instr_of(0)); err_cnt++; end vec_cnt++;
    tick();
  endtask

  task automatic test_reload();
    set_addrs(12'd0, 12'd1, 12'd2, 12'd3);
    fetch_req = 4'b0100;
    tick();
    if (fetch_valid !== 4'b0100) begin $display("FAIL rl_inflight_valid: got %b want 0100", fetch_valid); err_cnt++; end vec_cnt++;
    if (instr_of(2) !== 17'h08003) begin $display("FAIL rl_inflight_instr: got %h want 08003", instr_of(2)); err_cnt++; end vec_cnt++;
    prog_start = 1'b1;
    fetch_req  = 4'b1111;
    tick();
    prog_start = 1'b0;
    if (fetch_valid !== 4'b0000) begin $display("FAIL rl_start_no_grant: got %b want 0000", fetch_valid); err_cnt++; end vec_cnt++;
    if (prog_ready !== 1'b1) begin $display("FAIL rl_prog_ready: got %b want 1", prog_ready); err_cnt++; end vec_cnt++;
    for (int i = 0; i < 4; i++) begin
      prog_valid = 1'b1;
      prog_data  = prog_a[i];
      prog_last  = (i == 3);
      tick();
      if (fetch_valid !== 4'b0000) begin $display("FAIL rl_load_no_valid[%0d]: got %b want 0000", i, fetch_valid); err_cnt++; end vec_cnt++;
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    if (mem_ready !== 1'b1) begin $display("FAIL rl_mem_ready: got %b want 1", mem_ready); err_cnt++; end vec_cnt++;
    if (instr_of(2) !== 17'h08003) begin $display("FAIL rl_hold_core2: got %h want 08003", instr_of(2)); err_cnt++; end vec_cnt++;
    tick();
    fetch_req = 4'b0000;
    if (fetch_valid !== 4'b1000) begin $display("FAIL rl_resume_valid: got %b want 1000", fetch_valid); err_cnt++; end vec_cnt++;
    if (instr_of(3) !== 17'h1F000) begin $display("FAIL rl_resume_instr: got %h want 1f000", instr_of(3)); err_cnt++; end vec_cnt++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
    fetch_req = '0; fetch_addr = '0;
    s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    s_req = '0; s_addr = '0;
    tick();
    test_reset();
    test_load();
    test_round_robin();
    test_coalesce();
    test_overflow();
    test_reset_mid_load();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
